// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite palette stage: RGB555 palette word,
// sprite pixel layout and the channel expansion / fade arithmetic.
package sprite_pkg;

    typedef struct packed {
        logic       unused;
        logic [4:0] b;
        logic [4:0] g;
        logic [4:0] r;
    } rgb555_t;

    typedef struct packed {
        logic [3:0] color;
        logic [3:0] pen;
    } obj_pix_t;

    localparam logic [3:0] TRANSPARENT_PEN_DEFAULT = 4'd0;

    // Replicate the top bits into the low bits so 5'h1F maps to 8'hFF.
    function automatic logic [7:0] expand5to8(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    // Brightness 31 is identity, 0 leaves ch>>5.
    function automatic logic [7:0] fade8(input logic [7:0] ch, input logic [4:0] brt);
        return 8'((14'(ch) * (14'(brt) + 14'd1)) >> 5);
    endfunction

endpackage

// File: rtl/palette_ram.sv
// True dual-port palette RAM: port A is the CPU read/write port with byte lanes,
// port B is the read-only video port. Both ports are clocked by the same clock.
module palette_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          a_we,
    input  logic [1:0]    a_be,
    input  logic          a_re,
    input  logic [AW-1:0] a_addr,
    input  logic [15:0]   a_wdata,
    output logic [15:0]   a_rdata,
    input  logic          b_en,
    input  logic [AW-1:0] b_addr,
    output logic [15:0]   b_rdata
);

    logic [15:0] mem [2**AW];

    // One process for both ports: a video read colliding with a CPU write of
    // the same entry returns the word as it was before that edge.
    always_ff @(posedge clk) begin
        if (a_we) begin
            if (a_be[0]) mem[a_addr][7:0]  <= a_wdata[7:0];
            if (a_be[1]) mem[a_addr][15:8] <= a_wdata[15:8];
        end
        if (a_re) a_rdata <= mem[a_addr];
        if (b_en) b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/sprite_palette.sv
// Sprite palette lookup: sprite pixel -> RGB555 palette -> 8-bit RGB + opacity.
// Define SPRITE_PALETTE_FADE_EN to add the brightness register and fade stage.
module sprite_palette
    import sprite_pkg::*;
#(
    parameter int         PAL_AW          = 8,
    parameter logic [3:0] TRANSPARENT_PEN = TRANSPARENT_PEN_DEFAULT
) (
    input  logic        CLK_32M,
    input  logic        RESET_N,
    input  logic        CE_PIX,
    input  logic [15:0] DIN,
    output logic [15:0] DOUT,
    output logic        DOUT_VALID,
    input  logic [19:1] A,
    input  logic [1:0]  BYTE_SEL,
    input  logic        PALCS,
    input  logic        MRD,
    input  logic        MWR,
    input  logic        HBLK,
    input  logic        VBLK,
    input  logic [7:0]  PIX_IN,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic        OBJ_OPAQUE
);

    logic [PAL_AW-1:0] cpu_addr;
    logic              cpu_wr;
    logic              cpu_rd;
    logic              brt_hit;
    logic              ram_we;
    logic              ram_re;
    logic [15:0]       cpu_rdata;
    logic              rd_valid_q;
    logic              brt_sel_q;
    logic [4:0]        brt_val;

    assign cpu_addr = A[PAL_AW:1];
    assign cpu_wr   = PALCS & MWR;
    // A write strobe wins over a read strobe in the same cycle.
    assign cpu_rd   = PALCS & MRD & ~MWR;

`ifdef SPRITE_PALETTE_FADE_EN
    assign brt_hit = A[PAL_AW+1] & (cpu_addr == '0);
`else
    assign brt_hit = 1'b0;
`endif

    assign ram_we = cpu_wr & ~brt_hit;
    assign ram_re = cpu_rd & ~brt_hit;

    // ---------------------------------------------------------------------
    // Palette storage
    // ---------------------------------------------------------------------
    obj_pix_t    pix_in_s;
    obj_pix_t    pix0;
    logic [15:0] vid_rdata;
    rgb555_t     vid_word;

    assign pix_in_s = obj_pix_t'(PIX_IN);
    assign vid_word = rgb555_t'(vid_rdata);

    palette_ram #(
        .AW (PAL_AW)
    ) u_ram (
        .clk     (CLK_32M),
        .a_we    (ram_we),
        .a_be    (BYTE_SEL),
        .a_re    (ram_re),
        .a_addr  (cpu_addr),
        .a_wdata (DIN),
        .a_rdata (cpu_rdata),
        .b_en    (CE_PIX),
        .b_addr  (PAL_AW'(pix0)),
        .b_rdata (vid_rdata)
    );

    // ---------------------------------------------------------------------
    // CPU read side. DOUT_VALID rises the cycle after PALCS&MRD (without
    // MWR) is sampled and stays high while the strobe is held; DOUT carries
    // the addressed word whenever DOUT_VALID is high and is zero otherwise.
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_valid_q <= 1'b0;
            brt_sel_q  <= 1'b0;
        end else begin
            rd_valid_q <= cpu_rd;
            brt_sel_q  <= cpu_rd & brt_hit;
        end
    end

    always_comb begin
        DOUT = '0;
        if (rd_valid_q) begin
            if (brt_sel_q) DOUT = {11'd0, brt_val};
            else           DOUT = cpu_rdata;
        end
    end

    assign DOUT_VALID = rd_valid_q;

    // ---------------------------------------------------------------------
    // Video pipeline: S0 latch, S1 palette read, S2 expand.
    // Valid bits make the first pixels after reset come out blank.
    // ---------------------------------------------------------------------
    logic       v0, blank0, opq0;
    logic       v1, blank1, opq1;
    logic [7:0] r2, g2, b2;
    logic       opq2;

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            pix0   <= '0;
            v0     <= 1'b0;
            blank0 <= 1'b1;
            opq0   <= 1'b0;
            v1     <= 1'b0;
            blank1 <= 1'b1;
            opq1   <= 1'b0;
            r2     <= '0;
            g2     <= '0;
            b2     <= '0;
            opq2   <= 1'b0;
        end else if (CE_PIX) begin
            pix0   <= pix_in_s;
            v0     <= 1'b1;
            blank0 <= HBLK | VBLK;
            opq0   <= (pix_in_s.pen != TRANSPARENT_PEN);
            v1     <= v0;
            blank1 <= blank0;
            opq1   <= opq0;
            if (v1 && !blank1) begin
                r2   <= expand5to8(vid_word.r);
                g2   <= expand5to8(vid_word.g);
                b2   <= expand5to8(vid_word.b);
                opq2 <= opq1;
            end else begin
                r2   <= '0;
                g2   <= '0;
                b2   <= '0;
                opq2 <= 1'b0;
            end
        end
    end

`ifdef SPRITE_PALETTE_FADE_EN
    logic [4:0] brt_q;
    logic [7:0] r3, g3, b3;
    logic       opq3;

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            brt_q <= 5'd31;
        end else if (cpu_wr && brt_hit && BYTE_SEL[0]) begin
            brt_q <= DIN[4:0];
        end
    end

    // Blanked pixels are already zero in S2, so scaling keeps them zero.
    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            r3   <= '0;
            g3   <= '0;
            b3   <= '0;
            opq3 <= 1'b0;
        end else if (CE_PIX) begin
            r3   <= fade8(r2, brt_q);
            g3   <= fade8(g2, brt_q);
            b3   <= fade8(b2, brt_q);
            opq3 <= opq2;
        end
    end

    assign brt_val    = brt_q;
    assign R          = r3;
    assign G          = g3;
    assign B          = b3;
    assign OBJ_OPAQUE = opq3;
`else
    assign brt_val    = 5'd0;
    assign R          = r2;
    assign G          = g2;
    assign B          = b2;
    assign OBJ_OPAQUE = opq2;
`endif

    // Address bits above the palette window and the spare palette bit are
    // intentionally ignored on the video path.
    logic unused_bits;
`ifdef SPRITE_PALETTE_FADE_EN
    assign unused_bits = ^{A[19:PAL_AW+2], vid_word.unused};
`else
    assign unused_bits = ^{A[19:PAL_AW+1], vid_word.unused};
`endif

endmodule

// File: tb/tb_sprite_palette.sv
// Bench for sprite_palette: random and directed stimulus, palette reference
// model, expected queues drained by a negedge monitor.
`timescale 1ns/1ps
module tb_sprite_palette;

`ifdef SPRITE_PALETTE_FADE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        CLK_32M = 1'b0;
    logic        RESET_N;
    logic        CE_PIX;
    logic [15:0] DIN;
    logic [15:0] DOUT;
    logic        DOUT_VALID;
    logic [19:1] A;
    logic [1:0]  BYTE_SEL;
    logic        PALCS;
    logic        MRD;
    logic        MWR;
    logic        HBLK;
    logic        VBLK;
    logic [7:0]  PIX_IN;
    logic [7:0]  R;
    logic [7:0]  G;
    logic [7:0]  B;
    logic        OBJ_OPAQUE;

    sprite_palette dut (
        .CLK_32M    (CLK_32M),
        .RESET_N    (RESET_N),
        .CE_PIX     (CE_PIX),
        .DIN        (DIN),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .A          (A),
        .BYTE_SEL   (BYTE_SEL),
        .PALCS      (PALCS),
        .MRD        (MRD),
        .MWR        (MWR),
        .HBLK       (HBLK),
        .VBLK       (VBLK),
        .PIX_IN     (PIX_IN),
        .R          (R),
        .G          (G),
        .B          (B),
        .OBJ_OPAQUE (OBJ_OPAQUE)
    );

    // clock / reset
    always #5 CLK_32M = ~CLK_32M;

    // scoreboard state
    logic [24:0] exp_q[$];
    logic [15:0] rd_q[$];
    logic [24:0] cur_exp;
    logic [15:0] pal [256];
    int          brt;
    logic [7:0]  pend_pix;
    logic        pend_blank;
    logic        have_pend;
    logic        ce_hit;
    logic        rd_hit;
    int          n_checks;
    int          n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: palette word -> {opaque, R, G, B}
    function automatic logic [24:0] lookup(input logic [7:0] p, input logic blank);
        logic [15:0] w;
        int c;
        int e;
        logic [7:0] ch [3];
        if (blank) return '0;
        w = pal[p];
        for (int i = 0; i < 3; i++) begin
            c = (int'(w) >> (5 * i)) & 31;
            e = c * 8 + c / 4;
`ifdef SPRITE_PALETTE_FADE_EN
            e = e * (brt + 1) / 32;
`endif
            ch[i] = 8'(e);
        end
        return {p[3:0] != 4'd0, ch[0], ch[1], ch[2]};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        rd_q.delete();
        for (int i = 0; i < LAT; i++) exp_q.push_back('0);
        have_pend = 1'b0;
        cur_exp   = '0;
        brt       = 31;
        ce_hit    = 1'b0;
        rd_hit    = 1'b0;
    endtask

    // driver: one clock with the given inputs, model updated at the edge
    task automatic step(input logic ce, input logic [7:0] pix, input logic blank,
                        input logic cs, input logic rd, input logic wr,
                        input logic [19:1] a, input logic [1:0] be, input logic [15:0] din);
        logic [7:0] ix;
        logic       is_brt;
        int         sel;
        sel      = $urandom_range(0, 2);
        CE_PIX   = ce;
        PIX_IN   = pix;
        HBLK     = blank && (sel != 1);
        VBLK     = blank && (sel != 0);
        PALCS    = cs;
        MRD      = rd;
        MWR      = wr;
        A        = a;
        BYTE_SEL = be;
        DIN      = din;
        @(posedge CLK_32M);
        ix = a[8:1];
`ifdef SPRITE_PALETTE_FADE_EN
        is_brt = a[9] && (ix == 8'd0);
`else
        is_brt = 1'b0;
`endif
        ce_hit = ce && RESET_N;
        rd_hit = cs && rd && !wr && RESET_N;
        if (rd_hit) rd_q.push_back(is_brt ? 16'(brt) : pal[ix]);
        if (ce_hit) begin
            if (have_pend) exp_q.push_back(lookup(pend_pix, pend_blank));
            pend_pix   = pix;
            pend_blank = blank;
            have_pend  = 1'b1;
        end
        if (cs && wr && RESET_N) begin
            if (is_brt) begin
                if (be[0]) brt = int'(din[4:0]);
            end else begin
                if (be[0]) pal[ix][7:0]  = din[7:0];
                if (be[1]) pal[ix][15:8] = din[15:8];
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'd0);
    endtask

    task automatic pixel(input logic [7:0] p, input logic blank);
        step(1'b1, p, blank, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'd0);
    endtask

    task automatic cpu_write(input int addr, input logic [1:0] be, input logic [15:0] d);
        step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 19'(addr), be, d);
    endtask

    task automatic cpu_read(input int addr);
        step(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 19'(addr), 2'b00, 16'd0);
    endtask

    task automatic mid_reset();
        #2;
        RESET_N = 1'b0;
        model_reset();
        #1;
        check("async_reset_rgb", {7'd0, OBJ_OPAQUE, R, G, B}, 32'd0);
        check("async_reset_dout_valid", {31'd0, DOUT_VALID}, 32'd0);
        repeat (2) idle();
        #3 RESET_N = 1'b1;
    endtask

    // monitor
    always @(negedge CLK_32M) begin
        if (ce_hit) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL video_queue: output advanced with no expected pixel at %0t", $time);
            end else begin
                cur_exp = exp_q.pop_front();
            end
        end
        check("video_pixel", {7'd0, OBJ_OPAQUE, R, G, B}, {7'd0, cur_exp});
        check("dout_valid", {31'd0, DOUT_VALID}, {31'd0, rd_hit});
        if (rd_hit) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                $display("FAIL dout_queue: read with no expected data at %0t", $time);
            end else begin
                check("dout", {16'd0, DOUT}, {16'd0, rd_q.pop_front()});
            end
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        RESET_N  = 1'b0;
        CE_PIX   = 1'b0;
        PIX_IN   = '0;
        HBLK     = 1'b0;
        VBLK     = 1'b0;
        PALCS    = 1'b0;
        MRD      = 1'b0;
        MWR      = 1'b0;
        A        = '0;
        BYTE_SEL = '0;
        DIN      = '0;
        model_reset();
        repeat (3) idle();
        #3 RESET_N = 1'b1;
        check("reset_dout", {16'd0, DOUT}, 32'd0);
        check("reset_rgb", {7'd0, OBJ_OPAQUE, R, G, B}, 32'd0);

        for (int i = 0; i < 256; i++) cpu_write(i, 2'b11, 16'($urandom));

        // full-white opaque entry
        cpu_write('h23, 2'b11, 16'h7FFF);
        pixel(8'h23, 1'b0);
        repeat (LAT) pixel(8'h00, 1'b1);
        check("white_pixel", {7'd0, OBJ_OPAQUE, R, G, B}, {7'd0, 1'b1, 24'hFFFFFF});

        // low-lane-only write and readback
        cpu_write('h40, 2'b11, 16'h0000);
        cpu_write('h40, 2'b01, 16'hAB1F);
        cpu_read('h40);
        check("byte_lane_valid", {31'd0, DOUT_VALID}, 32'd1);
        check("byte_lane_dout", {16'd0, DOUT}, 32'h001F);
        idle();
        pixel(8'h40, 1'b0);
        repeat (LAT) pixel(8'h00, 1'b1);
        check("red_transparent", {7'd0, OBJ_OPAQUE, R, G, B}, {7'd0, 1'b0, 24'hFF0000});

        // transparent pen keeps colour; blank zeroes it
        cpu_write('h50, 2'b11, 16'h7C00);
        pixel(8'h50, 1'b0);
        repeat (LAT) pixel(8'h00, 1'b1);
        check("blue_transparent", {7'd0, OBJ_OPAQUE, R, G, B}, {7'd0, 1'b0, 24'h0000FF});
        pixel(8'h50, 1'b1);
        repeat (LAT) pixel(8'h00, 1'b1);
        check("blanked", {7'd0, OBJ_OPAQUE, R, G, B}, 32'd0);

        // simultaneous read and write: write wins, no read data
        step(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 19'h33, 2'b11, 16'h1234);
        check("rdwr_no_valid", {31'd0, DOUT_VALID}, 32'd0);

        // stream with a 5-cycle CE_PIX gap
        for (int i = 0; i < 12; i++) begin
            pixel(8'($urandom), $urandom_range(0, 4) == 0);
            if (i == 5) repeat (5) idle();
        end

        // CPU write colliding with the video read of the same entry
        cpu_write('h10, 2'b11, 16'h001F);
        pixel(8'h10, 1'b0);
        step(1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b1, 19'h10, 2'b11, 16'h03E0);
        repeat (LAT - 1) pixel(8'h00, 1'b1);
        check("collide_old", {7'd0, OBJ_OPAQUE, R, G, B}, {7'd0, 1'b0, 24'hFF0000});
        pixel(8'h00, 1'b1);
        check("collide_new", {7'd0, OBJ_OPAQUE, R, G, B}, {7'd0, 1'b0, 24'h00FF00});

        // random traffic
        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 9);
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 6) == 0,
                 op < 6, (op >= 2 && op < 6), (op < 2 || op == 5),
                 19'($urandom_range(0, 255)), 2'($urandom), 16'($urandom));
        end
        repeat (LAT + 1) pixel(8'h00, 1'b1);

`ifdef SPRITE_PALETTE_FADE_EN
        cpu_write(256, 2'b01, 16'h000F);
        cpu_read(256);
        check("brt_readback", {16'd0, DOUT}, 32'h000F);
        cpu_write('h77, 2'b11, 16'h7FFF);
        pixel(8'h77, 1'b0);
        repeat (LAT) pixel(8'h00, 1'b1);
        check("fade_half", {7'd0, OBJ_OPAQUE, R, G, B}, {7'd0, 1'b1, 24'h7F7F7F});
        pixel(8'h77, 1'b0);
        pixel(8'h23, 1'b0);
        mid_reset();
        cpu_read(256);
        check("brt_after_reset", {16'd0, DOUT}, 32'd31);
`else
        cpu_write(0, 2'b11, 16'h5A5A);
        cpu_read(256);
        check("alias_entry0", {16'd0, DOUT}, 32'h5A5A);
        pixel(8'h23, 1'b0);
        pixel(8'h40, 1'b0);
        mid_reset();
`endif
        for (int i = 0; i < 20; i++) pixel(8'($urandom), $urandom_range(0, 4) == 0);
        repeat (LAT + 1) pixel(8'h00, 1'b1);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
